// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the UART transmitter with its transmit FIFO.
//   wr_en      : write request from the producer
//   data       : word to enqueue, sampled on the accept edge
//   fifo_full  : FIFO holds FIFO_DEPTH words
//   fifo_empty : FIFO holds no words
//   overflow   : one-cycle pulse when a write is dropped
//   tx_busy    : a frame is on the line
//   tx_done    : one-cycle pulse at frame end
//   tx         : serial line, idle high
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 wr_en;
    logic [DATA_BITS-1:0] data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 overflow;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx;

    modport master (
        output wr_en,
        output data,
        input  fifo_full,
        input  fifo_empty,
        input  overflow,
        input  tx_busy,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  wr_en,
        input  data,
        output fifo_full,
        output fifo_empty,
        output overflow,
        output tx_busy,
        output tx_done,
        output tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Serialises queued words LSB-first: start bit, DATA_BITS data bits, an
// optional parity bit, then STOP_BITS stop bits, each CLKS_PER_BIT clocks.
// Queued frames go out back-to-back with no idle gap.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : uart_tx_fifo_if.slave (wr_en/data in; flags, pulses, tx out)
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // FSM and datapath state
    state_e               state_q,     state_d;
    logic [BAUD_W-1:0]    baud_q,      baud_d;
    logic [BIT_W-1:0]     bit_q,       bit_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 parity_q,    parity_d;
    logic                 frame_end_q, frame_end_d;

    // FIFO state
    logic [FIFO_DEPTH-1:0][DATA_BITS-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic                 full_q,      full_d;
    logic                 empty_q,     empty_d;
    logic                 overflow_q,  overflow_d;

    // Registered line outputs
    logic                 tx_q,        tx_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;

    logic                 push;
    logic                 pop;
    logic                 baud_last;
    logic [DATA_BITS-1:0] head;

    assign head = mem_q[rd_ptr_q];

    // Next-state logic for the FSM, FIFO and registered outputs
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        frame_end_d = 1'b0;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop         = 1'b0;
        push        = bus.wr_en && !full_q;
        baud_last   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        // Frame sequencing; the baud counter only runs inside a frame
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d       = '0;
                        frame_end_d = 1'b1;
                        // Chain straight into the next frame when work is queued
                        if (!empty_q) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Latch the head word and its parity so later writes cannot disturb the frame
        if (pop) begin
            shift_d  = head;
            parity_d = (PARITY == 1) ? ~(^head) : (^head);
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = bus.data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d     = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d    = (count_d == '0);
        // A write against a full FIFO is dropped even if a pop frees a slot this edge
        overflow_d = bus.wr_en && full_q;

        // Line level follows the current state, so tx trails the state by one edge
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
            S_PARITY: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE);
        // Delayed one edge so the pulse lines up with tx_busy falling or the next start bit
        done_d = frame_end_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            frame_end_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            frame_end_q <= frame_end_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // FIFO storage; contents are don't-care after reset since the pointers clear
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.fifo_full  = full_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = overflow_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.tx         = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: dut_a uses even parity / 1 stop bit,
// dut_b uses odd parity / 2 stop bits; both 8 data bits, 4 clocks per bit.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt_a = 0;
    int   base;
    int   bad;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) bus_a ();
    uart_tx_fifo_if #(.DATA_BITS(8)) bus_b ();

    uart_tx_fifo #(
        .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    uart_tx_fifo #(
        .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    always @(posedge clk) begin
        if (bus_a.tx_done === 1'b1) done_cnt_a <= done_cnt_a + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the first cycle of a start bit; ends at the cycle where tx_done is high
    task automatic check_frame(input bit sel_b, input logic [7:0] w);
        int   nlev = sel_b ? 12 : 11;
        logic par  = sel_b ? ~(^w) : (^w);
        logic exp;
        for (int l = 0; l < nlev; l++) begin
            for (int c = 0; c < 4; c++) begin
                if (l == 0)      exp = 1'b0;
                else if (l <= 8) exp = w[l-1];
                else if (l == 9) exp = par;
                else             exp = 1'b1;
                chk("frame_tx", sel_b ? bus_b.tx : bus_a.tx, exp);
                chk("frame_busy", sel_b ? bus_b.tx_busy : bus_a.tx_busy, 1);
                if (l != 0 || c != 0)
                    chk("frame_no_done", sel_b ? bus_b.tx_done : bus_a.tx_done, 0);
                step();
            end
        end
        chk("frame_end_done", sel_b ? bus_b.tx_done : bus_a.tx_done, 1);
    endtask

    task automatic wait_idle_a(input int budget);
        int i = 0;
        while ((bus_a.tx_busy !== 1'b0 || bus_a.fifo_empty !== 1'b1) && i < budget) begin
            step();
            i++;
        end
        chk("idle_reached", {bus_a.tx_busy, bus_a.fifo_empty}, 2'b01);
    endtask

    initial begin
        reset_n     = 1'b0;
        bus_a.wr_en = 1'b0;
        bus_a.data  = '0;
        bus_b.wr_en = 1'b0;
        bus_b.data  = '0;
        step();
        step();
        // Reset state
        chk("rst_tx_a",       bus_a.tx, 1);
        chk("rst_busy_a",     bus_a.tx_busy, 0);
        chk("rst_done_a",     bus_a.tx_done, 0);
        chk("rst_ovf_a",      bus_a.overflow, 0);
        chk("rst_full_a",     bus_a.fifo_full, 0);
        chk("rst_empty_a",    bus_a.fifo_empty, 1);
        chk("rst_tx_b",       bus_b.tx, 1);
        chk("rst_empty_b",    bus_b.fifo_empty, 1);
        reset_n = 1'b1;
        step();

        // 1: single word 0xA5
        bus_a.wr_en = 1'b1;
        bus_a.data  = 8'hA5;
        step();
        bus_a.wr_en = 1'b0;
        chk("s1_empty_fall", bus_a.fifo_empty, 0);
        chk("s1_tx_n0",      bus_a.tx, 1);
        step();
        chk("s1_tx_n1",      bus_a.tx, 1);
        chk("s1_busy_n1",    bus_a.tx_busy, 0);
        chk("s1_empty_pop",  bus_a.fifo_empty, 1);
        step();
        check_frame(1'b0, 8'hA5);
        chk("s1_busy_fall",  bus_a.tx_busy, 0);
        chk("s1_tx_idle",    bus_a.tx, 1);
        step();
        chk("s1_done_clr",   bus_a.tx_done, 0);
        step();

        // 2: three words back-to-back
        bus_a.wr_en = 1'b1;
        bus_a.data  = 8'h01;
        step();
        bus_a.data  = 8'h02;
        step();
        bus_a.data  = 8'h03;
        step();
        bus_a.wr_en = 1'b0;
        check_frame(1'b0, 8'h01);
        chk("s2_empty_mid",  bus_a.fifo_empty, 0);
        check_frame(1'b0, 8'h02);
        chk("s2_empty_last", bus_a.fifo_empty, 1);
        check_frame(1'b0, 8'h03);
        chk("s2_busy_fall",  bus_a.tx_busy, 0);
        step();
        chk("s2_done_clr",   bus_a.tx_done, 0);
        step();

        // 3: six writes while idle, one dropped
        base = done_cnt_a;
        for (int i = 0; i < 6; i++) begin
            bus_a.wr_en = 1'b1;
            bus_a.data  = 8'(8'h10 + i);
            step();
            if (i == 4) chk("s3_full", bus_a.fifo_full, 1);
        end
        bus_a.wr_en = 1'b0;
        chk("s3_overflow",   bus_a.overflow, 1);
        step();
        chk("s3_ovf_pulse",  bus_a.overflow, 0);
        wait_idle_a(400);
        step();
        chk("s3_frames",     done_cnt_a - base, 5);
        step();

        // 4: odd parity, two stop bits
        bus_b.wr_en = 1'b1;
        bus_b.data  = 8'hFF;
        step();
        bus_b.wr_en = 1'b0;
        step();
        chk("s4_tx_n1",      bus_b.tx, 1);
        step();
        check_frame(1'b1, 8'hFF);
        chk("s4_busy_fall",  bus_b.tx_busy, 0);
        step();
        bus_b.wr_en = 1'b1;
        bus_b.data  = 8'h01;
        step();
        bus_b.wr_en = 1'b0;
        step();
        step();
        check_frame(1'b1, 8'h01);
        chk("s4_busy_fall2", bus_b.tx_busy, 0);
        step();

        // 5: reset mid-DATA with two words queued
        for (int i = 0; i < 3; i++) begin
            bus_a.wr_en = 1'b1;
            bus_a.data  = 8'(8'h31 + i);
            step();
        end
        bus_a.wr_en = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("s5_busy_pre",   bus_a.tx_busy, 1);
        base    = done_cnt_a;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("s5_tx",         bus_a.tx, 1);
        chk("s5_busy",       bus_a.tx_busy, 0);
        chk("s5_empty",      bus_a.fifo_empty, 1);
        chk("s5_full",       bus_a.fifo_full, 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus_a.tx !== 1'b1 || bus_a.tx_busy !== 1'b0) bad++;
        end
        chk("s5_quiet",      bad, 0);
        chk("s5_no_done",    done_cnt_a - base, 0);

        // 6: write against a full FIFO on the STOP->START pop edge
        for (int i = 0; i < 5; i++) begin
            bus_a.wr_en = 1'b1;
            bus_a.data  = 8'(8'h41 + i);
            step();
        end
        bus_a.wr_en = 1'b0;
        chk("s6_full",       bus_a.fifo_full, 1);
        base = done_cnt_a;
        for (int i = 0; i < 40; i++) step();
        bus_a.wr_en = 1'b1;
        bus_a.data  = 8'h77;
        step();
        bus_a.wr_en = 1'b0;
        chk("s6_overflow",   bus_a.overflow, 1);
        chk("s6_not_full",   bus_a.fifo_full, 0);
        chk("s6_not_empty",  bus_a.fifo_empty, 0);
        step();
        chk("s6_done1",      bus_a.tx_done, 1);
        check_frame(1'b0, 8'h42);
        wait_idle_a(400);
        step();
        chk("s6_frames",     done_cnt_a - base, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. It serialises words LSB-first with configurable word length, parity mode, stop-bit count and baud divisor. It sits between a parallel producer (CPU or register block) and the off-chip `tx` pin. Queued frames are sent back-to-back with no idle gap.

## Interface
Parameters:
- `DATA_BITS`, 8: word length, legal 5..9.
- `CLKS_PER_BIT`, 16: clocks per bit period, legal >= 2.
- `PARITY`, 0: parity mode.
  - 0: none.
  - 1: odd.
  - 2: even.
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, >= 2.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `wr_en`  in  1  write request; accepted when `wr_en && !fifo_full`.
- `data`  in  `DATA_BITS`  word to enqueue; sampled on the accept edge.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `fifo_empty`  out  1  FIFO holds no words.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `tx_busy`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse at frame end.
- `tx`  out  1  serial line; idle high.

## Operation
Reset (`reset_n` = 0 at a rising edge) sets:
- `tx`=1, `tx_busy`=0, `tx_done`=0, `overflow`=0, `fifo_full`=0, `fifo_empty`=1.
- FIFO pointers, count, bit counter and baud counter to 0; FSM to IDLE.
- Queued words are discarded. A frame in progress is abandoned and `tx` returns high on the same edge.

FIFO:
- Occupancy counter is `$clog2(FIFO_DEPTH)+1` bits; pointers wrap modulo `FIFO_DEPTH`.
- Flags are registered and reflect occupancy after the current edge.
- A write while `fifo_full` is dropped and raises `overflow`, even if a pop occurs on the same edge.
- A simultaneous accepted write and pop leaves the count unchanged.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1.
  - If `!fifo_empty`, pop the head into the shift register and go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: send `DATA_BITS` bits, LSB first, `CLKS_PER_BIT` cycles each.
  - After the last bit, go to PARITY if `PARITY`!=0, else to STOP.
- PARITY: send one bit for `CLKS_PER_BIT` cycles.
  - Even mode: XOR of the word bits.
  - Odd mode: the inverse of that XOR.
- STOP: `tx`=1 for `STOP_BITS*CLKS_PER_BIT` cycles.
  - On the final cycle, pulse `tx_done`.
  - If the FIFO is non-empty on that edge, pop and go directly to START; otherwise go to IDLE.

Other rules:
- The baud counter is sized `$clog2(CLKS_PER_BIT)` bits. It counts 0..`CLKS_PER_BIT-1`, resets to 0 on every bit boundary and never free-runs.
- Parity is computed from the latched word, so FIFO writes during a frame cannot disturb it.
- `tx_busy` is high in every state except IDLE.

## Timing
- Frame length F = (1 + `DATA_BITS` + (`PARITY`!=0) + `STOP_BITS`) * `CLKS_PER_BIT` cycles exactly.
- Latency from idle: for a write accepted at edge N with the FIFO empty and the FSM in IDLE:
  - `fifo_empty` falls after edge N.
  - The pop occurs at edge N+1.
  - `tx`=0 and `tx_busy`=1 after edge N+2.
- `tx` is a registered output, glitch-free, and changes only on bit boundaries.
- `tx_done` is high during the single cycle following the last stop-bit cycle's edge. It coincides with either:
  - `tx_busy` falling (FIFO empty), or
  - `tx` falling for the next start bit (FIFO non-empty).
- Back-to-back frames have zero idle cycles. Start edges are exactly F cycles apart.
- Producer throughput: one write per cycle until `fifo_full`.

## Test plan
All scenarios use `DATA_BITS`=8, `CLKS_PER_BIT`=4, `PARITY`=2, `STOP_BITS`=1, `FIFO_DEPTH`=4, so F=44.

1. Write 0xA5 once.
   - `tx` low after 2 edges.
   - Bit sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; each level held 4 cycles.
   - `tx_done` pulses once 44 cycles after `tx` falls.
   - `tx_busy` then falls.
2. Write 0x01, 0x02, 0x03 on consecutive cycles.
   - Three frames with start edges exactly 44 cycles apart and no idle high between them.
   - Three `tx_done` pulses.
   - `fifo_empty` rises after the third pop.
3. Write 6 words on consecutive cycles while idle.
   - 5 accepted (1 popped + 4 queued).
   - `fifo_full`=1.
   - 6th write dropped with a 1-cycle `overflow` pulse.
   - Exactly 5 frames transmitted.
4. Rerun with `PARITY`=1 and `STOP_BITS`=2 (F=48); write 0xFF.
   - Parity bit = 1.
   - Stop high for 8 cycles.
   - `tx_done` 48 cycles after start.
5. Deassert `reset_n` for 1 cycle mid-DATA with 2 words queued.
   - After that edge: `tx`=1, `tx_busy`=0, `fifo_empty`=1.
   - No `tx_done`.
   - No further frames without new writes.
6. Write at the same edge as the STOP→START pop, with the FIFO holding 4 words.
   - Write dropped with `overflow`=1.
   - Count goes to 3.
   - Frames remain intact.
